// File: rtl/instr_fetch.sv
// instr_fetch: drives a synchronous instruction ROM, buffers returned words in a
// 2-entry queue and hands them to decode over valid/ready; handles redirects and HALT.
module instr_fetch #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 1,
  parameter logic [5:0] HALT_OPCODE = 6'b010001
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr,
  output logic                  halted
);
  logic [ADDR_WIDTH-1:0] r_pc, r_inflight_pc;
  logic                  r_inflight, r_halted;
  logic [1:0]            r_count;
  logic [DATA_WIDTH-1:0] r_word [2];
  logic [ADDR_WIDTH-1:0] r_wpc [2];
  logic                  w_pop, w_push, w_halt_ret, w_issue;
  logic [2:0]            w_occ;
  logic [1:0]            w_base;
  assign w_pop      = (r_count != 2'd0) && instr_ready;
  assign w_push     = r_inflight && !redirect;
  assign w_halt_ret = w_push && (rom_q[DATA_WIDTH-1 -: 6] == HALT_OPCODE);
  // Occupancy after this cycle's pop, counting the word still in flight.
  assign w_occ      = {1'b0, r_count} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue    = !r_halted && !redirect && !w_halt_ret && (w_occ < 3'd2);
  assign w_base     = r_count - {1'b0, w_pop};
  assign rom_addr    = r_pc;
  assign instr       = r_word[0];
  assign instr_pc    = r_wpc[0];
  assign instr_valid = r_count != 2'd0;
  assign halted      = r_halted;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_halted      <= 1'b0;
      r_count       <= 2'd0;
      r_word[0]     <= '0;
      r_word[1]     <= '0;
      r_wpc[0]      <= '0;
      r_wpc[1]      <= '0;
    end else if (redirect) begin
      r_pc       <= redirect_addr;
      r_inflight <= 1'b0;
      r_halted   <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_pc;
        r_pc          <= r_pc + ADDR_WIDTH'(1);
      end
      // Shift only when a second entry exists so the head holds once the queue drains.
      if (w_pop && r_count == 2'd2) begin
        r_word[0] <= r_word[1];
        r_wpc[0]  <= r_wpc[1];
      end
      if (w_push) begin
        r_word[w_base[0]] <= rom_q;
        r_wpc[w_base[0]]  <= r_inflight_pc;
      end
      r_count <= w_base + {1'b0, w_push};
      if (w_halt_ret) r_halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed checks of instr_fetch against a synchronous ROM model.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_ready = 1'b0;
  logic        redirect = 1'b0;
  logic [8:0]  redirect_addr = '0;
  logic [8:0]  rom_addr, rom_addr_w, instr_pc, instr_pc_w;
  logic [31:0] rom_q, rom_q_w, instr, instr_w;
  logic        instr_valid, instr_valid_w, halted, halted_w;
  logic [31:0] rom [512];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom_q   <= rom[rom_addr];
    rom_q_w <= rom[rom_addr_w];
  end

  instr_fetch dut (
    .clk(clk), .reset(reset), .rom_addr(rom_addr), .rom_q(rom_q),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .redirect(redirect),
    .redirect_addr(redirect_addr), .halted(halted)
  );

  instr_fetch #(.RESET_PC(9'd510)) dut_w (
    .clk(clk), .reset(reset), .rom_addr(rom_addr_w), .rom_q(rom_q_w),
    .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w),
    .instr_ready(1'b1), .redirect(1'b0),
    .redirect_addr(9'd0), .halted(halted_w)
  );

  function automatic logic [31:0] word(input int a);
    return (a == 7) ? {6'b010001, 26'(a)} : {6'b000000, 26'(a) ^ 26'h0A5_0000};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = word(i);
    @(negedge clk);
    chk("rst_rom_addr", 32'(rom_addr), 32'd1);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", 32'(instr_pc), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_wrap_addr", 32'(rom_addr_w), 32'd510);
    reset = 1'b0;
    instr_ready = 1'b1;
    step();
    chk("first_issue_valid", 32'(instr_valid), 32'd0);
    chk("first_issue_addr", 32'(rom_addr), 32'd2);
    chk("wrap_first_valid", 32'(instr_valid_w), 32'd0);
    for (int p = 1; p <= 7; p++) begin
      step();
      chk("stream_valid", 32'(instr_valid), 32'd1);
      chk("stream_pc", 32'(instr_pc), 32'(p));
      chk("stream_word", instr, word(p));
      if (p <= 4) chk("wrap_pc", 32'(instr_pc_w), 32'((509 + p) % 512));
    end
    chk("halt_flag", 32'(halted), 32'd1);
    chk("halt_addr", 32'(rom_addr), 32'd8);
    step();
    chk("halt_drained_valid", 32'(instr_valid), 32'd0);
    chk("halt_hold_pc", 32'(instr_pc), 32'd7);
    step();
    chk("halt_still_addr", 32'(rom_addr), 32'd8);
    chk("halt_still_valid", 32'(instr_valid), 32'd0);
    redirect = 1'b1;
    redirect_addr = 9'd1;
    step();
    redirect = 1'b0;
    chk("unhalt_flag", 32'(halted), 32'd0);
    chk("unhalt_addr", 32'(rom_addr), 32'd1);
    step();
    chk("unhalt_valid_r1", 32'(instr_valid), 32'd0);
    step();
    chk("unhalt_pc1", 32'(instr_pc), 32'd1);
    step();
    chk("unhalt_pc2", 32'(instr_pc), 32'd2);
    step();
    chk("bp_head", 32'(instr_pc), 32'd3);
    instr_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_hold_pc", 32'(instr_pc), 32'd3);
      chk("bp_hold_valid", 32'(instr_valid), 32'd1);
      chk("bp_stall_addr", 32'(rom_addr), 32'd5);
    end
    instr_ready = 1'b1;
    for (int p = 4; p <= 6; p++) begin
      step();
      chk("bp_resume_pc", 32'(instr_pc), 32'(p));
      chk("bp_resume_valid", 32'(instr_valid), 32'd1);
    end
    redirect = 1'b1;
    redirect_addr = 9'd1;
    step();
    redirect = 1'b0;
    step();
    step();
    chk("re_pc1", 32'(instr_pc), 32'd1);
    step();
    step();
    chk("re_head3", 32'(instr_pc), 32'd3);
    redirect = 1'b1;
    redirect_addr = 9'h40;
    step();
    redirect = 1'b0;
    chk("redir_flush_valid", 32'(instr_valid), 32'd0);
    chk("redir_addr", 32'(rom_addr), 32'h40);
    step();
    chk("redir_r1_valid", 32'(instr_valid), 32'd0);
    step();
    chk("redir_r2_valid", 32'(instr_valid), 32'd1);
    chk("redir_r2_pc", 32'(instr_pc), 32'h40);
    chk("redir_r2_word", instr, word(32'h40));
    step();
    chk("redir_next_pc", 32'(instr_pc), 32'h41);
    step();
    chk("redir_next2_pc", 32'(instr_pc), 32'h42);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_valid", 32'(instr_valid), 32'd0);
    chk("async_halted", 32'(halted), 32'd0);
    chk("async_addr", 32'(rom_addr), 32'd1);
    chk("async_wrap_addr", 32'(rom_addr_w), 32'd510);
    @(negedge clk);
    step();
    chk("async_held_valid", 32'(instr_valid), 32'd0);
    reset = 1'b0;
    step();
    chk("restart_r1_valid", 32'(instr_valid), 32'd0);
    step();
    chk("restart_pc1", 32'(instr_pc), 32'd1);
    chk("restart_wrap_pc", 32'(instr_pc_w), 32'd510);
    step();
    chk("restart_pc2", 32'(instr_pc), 32'd2);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
